// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte write handshake into the UART transmit FIFO
//   tx_data_valid  master->slave  byte offered this cycle
//   tx_data        master->slave  byte value
//   tx_ready       slave->master  FIFO has room; byte taken when valid && ready
interface uart_tx_fifo_if;
  logic       tx_data_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  modport master (output tx_data_valid, tx_data, input tx_ready);
  modport slave  (input tx_data_valid, tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, back-to-back frames from a FIFO
//   clk_i     system clock, rising edge
//   rst       asynchronous active-high reset
//   bus       slave side of the byte write handshake
//   uart_tx   serial line, idles high
//   tx_busy   frame in progress or bytes queued
//   fifo_cnt  bytes queued, 0..DEPTH
//   Define UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
module uart_tx_fifo #(
  parameter int CLK_PER   = 50_000_000,
  parameter int BAND_RATE = 9600,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk_i,
  input  logic              rst,
  uart_tx_fifo_if.slave     bus,
  output logic              uart_tx,
  output logic              tx_busy,
  output logic [ADDR_W:0]   fifo_cnt
);
  localparam int BAUD_DIV = CLK_PER / BAND_RATE;
  localparam int CNT_W = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic              wr, pop, last;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif
  assign bus.tx_ready = cnt_q != (ADDR_W+1)'(DEPTH);
  assign wr = bus.tx_data_valid && bus.tx_ready;
  assign last = baud_q == BAUD_LAST;
  assign uart_tx = tx_q;
  assign tx_busy = state_q != IDLE || cnt_q != '0;
  assign fifo_cnt = cnt_q;
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = bus.tx_data;
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    cnt_d = cnt_q + (ADDR_W+1)'(wr) - (ADDR_W+1)'(pop);
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    shift_d = shift_q;
    pop = 1'b0;
    baud_d = (state_q == IDLE || last) ? '0 : baud_q + CNT_W'(1);
    case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop = 1'b1;
        state_d = START;
      end
      START: if (last) begin
        state_d = DATA;
        idx_d = '0;
      end
      DATA: if (last) begin
        shift_d = shift_q >> 1;
        idx_d = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (idx_q == 3'd7) state_d = PARITY;
`else
        if (idx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (last) state_d = STOP;
`endif
      STOP: if (last) begin
        pop = cnt_q != '0;
        state_d = pop ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
    par_d = pop ? ^mem_q[rd_ptr_q] : par_q;
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_q : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  always_ff @(posedge clk_i) mem_q <= mem_d;
endmodule
